// File: rtl/md_defs.sv
// Shared multiply/divide definitions: op encodings, FSM states and op-class helpers.
// Also imported by the control decoder.
package md_defs;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops 0..3 are the multi-cycle arithmetic ops.
    function automatic logic is_multi(input logic [OP_W-1:0] op);
        return ~op[2];
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return ~op[2] & op[1];
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage multiply/divide handshake: operands and op in, busy/stall and HI/LO out.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             md_read;
    logic             busy;
    logic             md_stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, md_read,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, md_read,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the pending HI/LO result.
// wr_c=0 means HI/LO must be left untouched (zero divisor or non-arithmetic op).
module md_calc
    import md_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c,
    output logic             wr_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Signed ops run as unsigned on magnitudes; most-negative / -1 falls out as
    // quotient 2^(WIDTH-1), which re-encodes to the most-negative value, remainder 0.
    always_comb begin
        sgn    = (op == MD_MULT) || (op == MD_DIV);
        a_neg  = sgn & a[WIDTH-1];
        b_neg  = sgn & b[WIDTH-1];
        prod   = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_safe = (b == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        hi_c = '0;
        lo_c = '0;
        wr_c = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                hi_c = prod[PW-1:WIDTH];
                lo_c = prod[WIDTH-1:0];
                wr_c = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                lo_c = (a_neg ^ b_neg) ? -q_mag : q_mag;
                hi_c = a_neg ? -r_mag : r_mag;
                wr_c = (b != '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Result is computed at start and held pending; the counter only models latency.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [WIDTH-1:0] calc_hi;
    logic [WIDTH-1:0] calc_lo;
    logic             calc_wr;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op   (md.op),
        .a    (md.a),
        .b    (md.b),
        .hi_c (calc_hi),
        .lo_c (calc_lo),
        .wr_c (calc_wr)
    );

    // Next state: starts are only honoured in IDLE, including on the completion edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            MD_IDLE: begin
                if (md.start) begin
                    if (is_multi(md.op)) begin
                        state_d   = MD_RUN;
                        cnt_d     = is_div(md.op) ? DIV_CNT : MULT_CNT;
                        pend_hi_d = calc_hi;
                        pend_lo_d = calc_lo;
                        pend_wr_d = calc_wr;
                    end else if (md.op == MD_MTHI) begin
                        hi_d = md.a;
                    end else if (md.op == MD_MTLO) begin
                        lo_d = md.a;
                    end
                end
            end
            MD_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign md.busy     = (state_q == MD_RUN);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
    assign md.md_stall = md.md_read & (md.busy | (md.start & is_multi(md.op)));

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits in the E stage beside the ALU.
- Accepts mult/multu/div/divu as multi-cycle operations with a start/busy handshake, and mthi/mtlo as single-cycle writes.
- Emits a stall request the hazard logic ORs into the existing stall signals (enPC, enD, clrE).

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..255).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is an md op; qualifies op.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6,7 reserved (no-op).
- a  input  WIDTH  rs operand (forwarded value).
- b  input  WIDTH  rt operand (forwarded value).
- md_read  input  1  D-stage instruction is mfhi, mflo or an md op (used for the stall request).
- busy  output  1  multi-cycle operation in flight.
- md_stall  output  1  combinational: md_read & (busy | (start & op<=3)).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset:
  - Applies on a clk edge with reset=1. Result: busy=0, hi=0, lo=0, counter=0, pending results cleared.
  - Reset mid-operation aborts the op; HI/LO are not updated.
- Idle and start=1 with op 0..3 (sampled edge T):
  - Operands are latched and the result is computed into pending registers; the count loads MULT_CYCLES or DIV_CYCLES.
  - busy=1 from cycle T+1 through T+N inclusive, where N is the selected latency.
  - hi/lo take the pending result at the edge ending cycle T+N; busy=0 in T+N+1 with the new hi/lo visible.
- Two states only, IDLE and RUN:
  - IDLE->RUN on start & op<=3.
  - RUN->IDLE when the count reaches 1.
  - The count decrements once per cycle in RUN.
- start while busy=1 (any op): ignored.
  - The pipeline guarantees this never happens via md_stall.
  - The bench flags it as a protocol error; RTL must not corrupt state.
- mthi/mtlo (op 4/5) while idle:
  - hi (or lo) := a at the same edge; busy stays 0; no latency.
- Arithmetic:
  - mult: signed 2*WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
  - multu: same split, unsigned product.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend (a).
  - divu: unsigned quotient and remainder.
  - div, a=most-negative and b=-1: lo=a (0x80000000 at WIDTH=32), hi=0; no trap.
  - div/divu with b=0: operation runs full DIV_CYCLES, HI/LO unchanged at completion.
- Reserved op (6,7) with start=1: no state change, busy stays 0.
- Simultaneous completion edge with new start=1: start is ignored (busy still 1 in that cycle); the next op is accepted one cycle later.

Decomposition:
- Shared package md_defs holds:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - state constants (MD_IDLE, MD_RUN)
- Also reused by the control decoder.
- One natural sub-module: md_calc (combinational), which produces the pending hi/lo from op, a and b, including the zero-divisor and overflow rules. The FSM, counter and registers stay in md_unit.

Test Plan:
- mult, a=0xFFFFFFFE(-2), b=3, MULT_CYCLES=5:
  - busy high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands: hi=0x00000002, lo=0xFFFFFFFA.
- div, a=-7 (0xFFFFFFF9), b=2, DIV_CYCLES=10:
  - busy high 10 cycles.
  - Then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
  - divu, a=7, b=2: lo=3, hi=1.
- Boundaries:
  - div a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
  - divu b=0 after hi=0x11, lo=0x22: busy 10 cycles, hi/lo remain 0x11/0x22.
- Interaction with busy:
  - mthi a=0xABCD while idle: hi=0xABCD next cycle, busy never asserts.
  - md_read=1 during busy: md_stall=1.
  - md_read=1 with start mult in the same cycle: md_stall=1.
  - A second start issued while busy is ignored and the first result commits intact.
- reset asserted at cycle 3 of a 10-cycle div:
  - Next cycle busy=0, hi=lo=0.
  - A fresh mult started afterwards completes with the correct result.
- Parametrisation: rebuild with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=1.
  - mult 0x8000*0x0002: busy for 1 cycle, hi=0xFFFF, lo=0x0000.
